// File: rtl/csi2_frame_sequencer.sv
// Frame/line timing sequencer for the pixel-to-CSI-2 path: produces fv/lv/dvalid and pixel
// coordinates, holds line blanking while the downstream line transfer is still busy.
module csi2_frame_sequencer #(
   parameter int unsigned H_ACTIVE    = 1280,
   parameter int unsigned H_BLANK     = 200,
   parameter int unsigned V_ACTIVE    = 720,
   parameter int unsigned FV_LV_SETUP = 16,
   parameter int unsigned LV_FV_HOLD  = 16,
   parameter int unsigned V_BLANK_CYC = 4000,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             pix_clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             tinit_done_i,
   input  logic [7:0]       frame_max_i,
   input  logic             txfr_busy_i,
   output logic             fv_o,
   output logic             lv_o,
   output logic             dvalid_o,
   output logic [CNT_W-1:0] pix_x_o,
   output logic [CNT_W-1:0] pix_y_o,
   output logic [7:0]       frame_cnt_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             abort_o
);

   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(FV_LV_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(LV_FV_HOLD - 1);
   localparam logic [CNT_W-1:0] VB_LAST    = CNT_W'(V_BLANK_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FV_SETUP = 3'd1,
      S_LINE_ACT = 3'd2,
      S_LINE_BLK = 3'd3,
      S_FV_HOLD  = 3'd4,
      S_VBLANK   = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       max_q, max_d;
   logic             fv_q, fv_d;
   logic             lv_q, lv_d;
   logic             dvalid_q, dvalid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             abort_q, abort_d;

   // State, counters and all output flops.
   always_ff @(posedge pix_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         cnt_q    <= 8'd0;
         max_q    <= 8'd0;
         fv_q     <= 1'b0;
         lv_q     <= 1'b0;
         dvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         x_q      <= x_d;
         y_q      <= y_d;
         cnt_q    <= cnt_d;
         max_q    <= max_d;
         fv_q     <= fv_d;
         lv_q     <= lv_d;
         dvalid_q <= dvalid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         abort_q  <= abort_d;
      end
   end

   // Next-state logic; a dropped tinit_done_i overrides every other transition.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      if ((state_q != S_IDLE) && !tinit_done_i) begin
         state_d = S_IDLE;
         timer_d = '0;
         x_d     = '0;
         abort_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable_i && tinit_done_i) begin
                  state_d = S_FV_SETUP;
                  timer_d = '0;
                  x_d     = '0;
                  y_d     = '0;
                  cnt_d   = 8'd0;
                  max_d   = frame_max_i;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FV_SETUP: begin
               if (timer_q == SETUP_LAST) begin
                  state_d = S_LINE_ACT;
                  timer_d = '0;
                  x_d     = '0;
                  y_d     = '0;
               end else begin
                  timer_d = timer_q + ONE;
               end
            end
            S_LINE_ACT: begin
               if (x_q == H_LAST) begin
                  x_d     = '0;
                  timer_d = '0;
                  if (y_q == V_LAST) begin
                     state_d = S_FV_HOLD;
                     cnt_d   = cnt_q + 8'd1;
                  end else begin
                     state_d = S_LINE_BLK;
                  end
               end else begin
                  x_d = x_q + ONE;
               end
            end
            S_LINE_BLK: begin
               // Timer parks at its last value while the previous line is still draining.
               if (timer_q >= HB_LAST) begin
                  if (!txfr_busy_i) begin
                     state_d = S_LINE_ACT;
                     timer_d = '0;
                     x_d     = '0;
                     y_d     = y_q + ONE;
                  end else begin
                     state_d = S_LINE_BLK;
                  end
               end else begin
                  timer_d = timer_q + ONE;
               end
            end
            S_FV_HOLD: begin
               if (timer_q == HOLD_LAST) begin
                  state_d = S_VBLANK;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + ONE;
               end
            end
            S_VBLANK: begin
               if (timer_q == VB_LAST) begin
                  timer_d = '0;
                  if ((max_q != 8'd0) && (cnt_q == max_q)) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else if (enable_i) begin
                     state_d = S_FV_SETUP;
                     x_d     = '0;
                     y_d     = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  timer_d = timer_q + ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         endcase
      end
      fv_d     = (state_d == S_FV_SETUP) || (state_d == S_LINE_ACT) ||
                 (state_d == S_LINE_BLK) || (state_d == S_FV_HOLD);
      lv_d     = (state_d == S_LINE_ACT);
      dvalid_d = lv_d;
      busy_d   = (state_d != S_IDLE);
   end

   assign fv_o        = fv_q;
   assign lv_o        = lv_q;
   assign dvalid_o    = dvalid_q;
   assign pix_x_o     = x_q;
   assign pix_y_o     = y_q;
   assign frame_cnt_o = cnt_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign abort_o     = abort_q;

endmodule

// File: tb/tb_csi2_frame_sequencer.sv
// Directed bench for csi2_frame_sequencer using small frame geometry and a per-cycle
// protocol monitor that measures pulse widths, blanking gaps and coordinate sequences.
module tb_csi2_frame_sequencer;

   localparam int CNT_W = 16;
   localparam int H_ACT = 4;

   logic             pix_clk = 1'b0;
   logic             reset_i;
   logic             enable_i;
   logic             tinit_done_i;
   logic [7:0]       frame_max_i;
   logic             txfr_busy_i;
   logic             fv_o, lv_o, dvalid_o, busy_o, done_o, abort_o;
   logic [CNT_W-1:0] pix_x_o, pix_y_o;
   logic [7:0]       frame_cnt_o;

   always #5 pix_clk = ~pix_clk;

   csi2_frame_sequencer #(
      .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .FV_LV_SETUP(2),
      .LV_FV_HOLD(2), .V_BLANK_CYC(5), .CNT_W(CNT_W)
   ) dut (
      .pix_clk_i(pix_clk), .reset_i(reset_i), .enable_i(enable_i),
      .tinit_done_i(tinit_done_i), .frame_max_i(frame_max_i), .txfr_busy_i(txfr_busy_i),
      .fv_o(fv_o), .lv_o(lv_o), .dvalid_o(dvalid_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
      .frame_cnt_o(frame_cnt_o), .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int fv_prev = 0, lv_prev = 0;
   int fv_rises = 0, lv_rises = 0, done_cnt = 0, abort_cnt = 0;
   int fv_run = 0, last_fv_len = 0, lv_run = 0, lv_bad = 0;
   int low_run = 0, done_low_run = 0;
   int gap_act = 0, gap_run = 0, gap_n = 0;
   int gap_len [64];
   int exp_x = 0, exp_y = 0, xerr = 0, yerr = 0, inv_err = 0;
   int b_fv, b_lv, b_done, b_abort, b_gap, b_lvbad;
   int n;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic monitor();
      if ((dvalid_o && !lv_o) || (lv_o && !fv_o)) inv_err++;
      if (fv_o && fv_prev == 0) begin
         fv_rises++; fv_run = 0; exp_y = 0; gap_act = 0;
      end
      if (fv_o) fv_run++;
      if (!fv_o && fv_prev == 1) last_fv_len = fv_run;
      if (done_o) begin done_cnt++; done_low_run = low_run; end
      if (fv_o) low_run = 0; else low_run++;
      if (abort_o) abort_cnt++;
      if (lv_o && lv_prev == 0) begin
         lv_rises++;
         if (int'(pix_y_o) != exp_y) yerr++;
         exp_y++;
         if (gap_act != 0) begin gap_len[gap_n % 64] = gap_run; gap_n++; end
         lv_run = 0;
      end
      if (lv_o) lv_run++;
      if (!lv_o && lv_prev == 1) begin
         if (lv_run != H_ACT) lv_bad++;
         gap_act = 1; gap_run = 0;
      end
      if (!lv_o && fv_o && gap_act != 0) gap_run++;
      if (dvalid_o) begin
         if (int'(pix_x_o) != exp_x) xerr++;
         exp_x++;
      end else begin
         exp_x = 0;
      end
      fv_prev = int'(fv_o);
      lv_prev = int'(lv_o);
   endtask

   task automatic tick();
      @(posedge pix_clk);
      #1;
      if (!reset_i) monitor();
   endtask

   task automatic snap();
      b_fv = fv_rises; b_lv = lv_rises; b_done = done_cnt;
      b_abort = abort_cnt; b_gap = gap_n; b_lvbad = lv_bad;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         tick(); cyc++;
         if (done_o) break;
      end
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         tick(); cyc++;
         if (!busy_o) break;
      end
   endtask

   task automatic start_run(input logic [7:0] fmax);
      frame_max_i = fmax; enable_i = 1'b1; tinit_done_i = 1'b1;
      tick();
   endtask

   initial begin
      reset_i = 1'b1; enable_i = 1'b1; tinit_done_i = 1'b1;
      frame_max_i = 8'd3; txfr_busy_i = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check_eq("rst_fv_lv_dv", int'({fv_o, lv_o, dvalid_o}), 0);
      check_eq("rst_xy", int'({pix_x_o, pix_y_o}), 0);
      check_eq("rst_frame_cnt", int'(frame_cnt_o), 0);
      check_eq("rst_busy_done_abort", int'({busy_o, done_o, abort_o}), 0);
      enable_i = 1'b0; txfr_busy_i = 1'b0;
      reset_i = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check_eq("idle_busy", int'(busy_o), 0);
      check_eq("idle_fv", int'(fv_o), 0);

      // single frame, no back-pressure
      snap();
      start_run(8'd1);
      check_eq("t2_fv_start", int'(fv_o), 1);
      check_eq("t2_lv_start", int'(lv_o), 0);
      enable_i = 1'b0;
      wait_done(n);
      check_eq("t2_done_cycle", n, 25);
      check_eq("t2_frame_cnt", int'(frame_cnt_o), 1);
      check_eq("t2_busy_at_done", int'(busy_o), 0);
      check_eq("t2_fv_len", last_fv_len, 20);
      check_eq("t2_vblank_len", done_low_run, 5);
      check_eq("t2_lv_pulses", lv_rises - b_lv, 3);
      check_eq("t2_lv_bad_len", lv_bad - b_lvbad, 0);
      check_eq("t2_gap_count", gap_n - b_gap, 2);
      check_eq("t2_gap0", gap_len[b_gap % 64], 2);
      check_eq("t2_gap1", gap_len[(b_gap + 1) % 64], 2);
      tick();
      check_eq("t2_done_pulse_end", int'(done_o), 0);
      check_eq("t2_done_count", done_cnt - b_done, 1);

      // blanking stretched by txfr_busy_i
      snap();
      start_run(8'd1);
      enable_i = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_eq("t3_line0_last_x", int'(pix_x_o), 3);
      txfr_busy_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check_eq("t3_still_blank", int'({fv_o, lv_o}), 2);
      txfr_busy_i = 1'b0;
      wait_done(n);
      check_eq("t3_done_cycle", n, 18);
      check_eq("t3_gap0_stretched", gap_len[b_gap % 64], 7);
      check_eq("t3_gap1", gap_len[(b_gap + 1) % 64], 2);
      check_eq("t3_fv_len", last_fv_len, 25);
      check_eq("t3_lv_pulses", lv_rises - b_lv, 3);
      check_eq("t3_lv_bad_len", lv_bad - b_lvbad, 0);

      // tinit_done_i dropped during line 1
      snap();
      start_run(8'd1);
      enable_i = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check_eq("t4_mid_line1_xy", int'({pix_y_o[3:0], pix_x_o[3:0]}), 8'h11);
      tinit_done_i = 1'b0;
      tick();
      check_eq("t4_abort_fv_lv_dv", int'({fv_o, lv_o, dvalid_o}), 0);
      check_eq("t4_abort_pulse", int'(abort_o), 1);
      check_eq("t4_abort_frame_cnt", int'(frame_cnt_o), 0);
      check_eq("t4_abort_busy", int'(busy_o), 0);
      tick();
      check_eq("t4_abort_pulse_end", int'(abort_o), 0);
      for (int i = 0; i < 5; i++) tick();
      check_eq("t4_no_done", done_cnt - b_done, 0);
      check_eq("t4_abort_count", abort_cnt - b_abort, 1);
      start_run(8'd1);
      enable_i = 1'b0;
      tick(); tick();
      check_eq("t4_restart_y", int'(pix_y_o), 0);
      check_eq("t4_restart_lv_x", int'({lv_o, pix_x_o[3:0]}), 16);
      wait_done(n);
      check_eq("t4_restart_done_cycle", n, 23);
      check_eq("t4_restart_frame_cnt", int'(frame_cnt_o), 1);

      // continuous mode, enable dropped during frame 4
      snap();
      start_run(8'd0);
      for (int i = 0; i < 79; i++) tick();
      check_eq("t5_frames_started", fv_rises - b_fv, 4);
      enable_i = 1'b0;
      wait_idle(n);
      check_eq("t5_idle_cycle", n, 21);
      check_eq("t5_frame_cnt", int'(frame_cnt_o), 4);
      check_eq("t5_no_done", done_cnt - b_done, 0);
      check_eq("t5_fv_rises", fv_rises - b_fv, 4);
      check_eq("t5_lv_pulses", lv_rises - b_lv, 12);

      // frame_max 2, enable dropped in frame 1, frame_max_i changed mid-run
      snap();
      start_run(8'd2);
      for (int i = 0; i < 4; i++) tick();
      enable_i = 1'b0;
      frame_max_i = 8'd1;
      wait_idle(n);
      check_eq("t6_idle_cycle", n, 21);
      check_eq("t6_frame_cnt", int'(frame_cnt_o), 1);
      check_eq("t6_no_done", done_cnt - b_done, 0);
      check_eq("t6_fv_rises", fv_rises - b_fv, 1);
      for (int i = 0; i < 5; i++) tick();
      check_eq("t6_stays_idle", int'({busy_o, fv_o}), 0);

      check_eq("x_sequence_errors", xerr, 0);
      check_eq("y_sequence_errors", yerr, 0);
      check_eq("invariant_errors", inv_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
